draw_engine: RTL and testbench
==============================

# draw_engine

Parametrised, queued successor to the single-command rectangle drawer in the graphics path. Accepts draw commands over a valid/ready handshake into a small command FIFO. Executes each command as a sequence of constant-colour write bursts to the SDRAM frame-buffer controller, splitting rows longer than `MAX_BURST` and clipping to the screen. Sits between the CPU-side graphics command register and the frame-buffer write port.

## Interface
- `SCREEN_W`, 640: screen width in pixels; frame-buffer row pitch.
- `SCREEN_H`, 480: screen height in pixels.
- `COORD_W`, 10: width of the x/y/w/h fields.
- `COLOR_W`, 16: pixel width (RGB565).
- `ADDR_W`, 22: pixel address width.
- `MAX_BURST`, 256: maximum burst length; range 1..1023.
- `CMD_DEPTH`, 4: FIFO depth; power of two.
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO not full.
- `cmd_op` in 8: opcode.
- `cmd_data` in 256: fields, LSB first: x, y, w, h (each `COORD_W` bits), then color (`COLOR_W` bits).
- `write_burst_data_req` in 1: controller consumes `rgb` this cycle.
- `write_burst_data_finish` in 1: current burst complete.
- `write_burst_req` out 1: burst request.
- `addr` out `ADDR_W`: burst start pixel address.
- `write_burst_len` out 10: burst length.
- `rgb` out `COLOR_W`: pixel data.
- `cmd_done` out 1: one-cycle pulse per retired command.
- `illegal_cmd` out 1: one-cycle pulse per dropped unknown opcode.
- `busy` out 1: engine not IDLE or FIFO non-empty.
- `fifo_level` out `$clog2(CMD_DEPTH)+1`: queued command count.

## Operation
- Opcodes:
  - `OP_NOP`=0x00 retires immediately with `cmd_done`.
  - `OP_RECT`=0x01 fills rectangle.
  - `OP_CLEAR`=0x02 fills the full screen with color; x/y/w/h are ignored.
  - Any other opcode: popped, `illegal_cmd` pulses, no `cmd_done`, no bursts.
- Push on `cmd_valid & cmd_ready`. Push while full is ignored (ready is low).
- States:
  - IDLE: FIFO non-empty → pop → LOAD.
  - LOAD: latch the fields and clip, then go to REQ. Go to IDLE instead, pulsing `cmd_done` or `illegal_cmd`, when the opcode is NOP/illegal, clipped w=0, or clipped h=0.
  - REQ: hold `write_burst_req` until the first `write_burst_data_req`, then DATA.
  - DATA: wait for `write_burst_data_finish`, then NEXT.
  - NEXT: advance the column; at row end, advance the row. Go to REQ if pixels remain, else IDLE with `cmd_done`.
- Clipping:
  - x≥`SCREEN_W` or y≥`SCREEN_H` → empty.
  - w_eff = min(w, `SCREEN_W`−x); h_eff = min(h, `SCREEN_H`−y).
  - Compute at `COORD_W`+1 bits so that no wrap-around occurs.
- Segmenting:
  - Each row emits ceil(w_eff/`MAX_BURST`) bursts; each burst is `MAX_BURST` long except the last, which carries the remainder.
  - `addr` = (y_cur·`SCREEN_W` + x_cur) truncated to `ADDR_W`.
  - OP_CLEAR is treated as x=0, y=0, w=`SCREEN_W`, h=`SCREEN_H`.
- Output stability: `addr`, `write_burst_len` and `rgb` are stable from REQ entry until the NEXT exit. `rgb` = latched color throughout.
- FIFO push and pop in the same cycle: level unchanged; allowed when full (ready stays low when full, so no push happens) and when empty (no pop happens).

## Timing
- Reset values: `write_burst_req`=0, `addr`=0, `write_burst_len`=0, `rgb`=0, `cmd_done`=0, `illegal_cmd`=0, `busy`=0, `fifo_level`=0, `cmd_ready`=1. State=IDLE.
- `rst` mid-burst:
  - `write_burst_req` drops on the next edge.
  - The FIFO is flushed; no `cmd_done` for the aborted command.
  - The controller shares `rst`.
- Latency:
  - Push on edge E0 → pop at E1 → LOAD → REQ at E2.
  - `write_burst_req` is high in the cycle after E2.
- Between bursts:
  - `write_burst_req` is low for exactly the one NEXT cycle after the `write_burst_data_finish` cycle.
  - `write_burst_data_finish` and `write_burst_data_req` are accepted in the same cycle.
- `cmd_done` is asserted in the cycle after the last NEXT, or the cycle after LOAD for trivial commands.

## Structure
- Package `draw_pkg`: opcode constants, state enum, and field offset helpers keyed on `COORD_W`/`COLOR_W`.
- Sub-module `draw_cmd_fifo`:
  - Synchronous FIFO, `CMD_DEPTH`×(8+256).
  - Registered outputs, plus full/empty/level.
- The sequencer, clipping and segmenting logic stay in `draw_engine`.

## Test plan
- RECT x=10, y=2, w=4, h=3, color=0xF800 → 3 bursts, len 4, addr 1290/1930/2570, then one `cmd_done`.
- RECT x=0, y=0, w=600, h=1 with `MAX_BURST`=256 → lens 256, 256, 88 at addr 0, 256, 512.
- RECT x=630, y=478, w=20, h=5 → clipped to 2 bursts, len 10, addr 306550 and 307190.
- Mixed RECT w=0, opcode 0x7F, NOP → no bursts, 2 `cmd_done` pulses and 1 `illegal_cmd` pulse, in order.
- 5 back-to-back pushes with `CMD_DEPTH`=4 while the engine is stalled (no `write_burst_data_finish`) → `cmd_ready` low after 4 accepted (the first has already been popped, so 5 are accepted in total), with `fifo_level` never exceeding 4. Release the controller → all retire in order.
- Assert `rst` mid-DATA of a CLEAR → the next cycle shows all outputs at their reset values and `fifo_level`=0. A fresh RECT afterwards executes normally.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared constants for the queued rectangle/clear draw engine: opcodes,
// sequencer states and command-field bit offsets.
package draw_pkg;
  localparam int CMD_OP_W   = 8;
  localparam int CMD_DATA_W = 256;

  localparam logic [CMD_OP_W-1:0] OP_NOP   = 8'h00;
  localparam logic [CMD_OP_W-1:0] OP_RECT  = 8'h01;
  localparam logic [CMD_OP_W-1:0] OP_CLEAR = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_DATA,
    ST_NEXT
  } state_e;

  typedef enum int {
    FLD_X     = 0,
    FLD_Y     = 1,
    FLD_W     = 2,
    FLD_H     = 3,
    FLD_COLOR = 4
  } field_e;

  // Fields are packed LSB first, each coordinate COORD_W wide, colour last.
  function automatic int field_lsb(input field_e f, input int coord_w);
    return int'(f) * coord_w;
  endfunction
endpackage

// File: rtl/draw_if.sv
// Command handshake plus frame-buffer burst write port of the draw engine.
// master = command source / memory controller side, slave = draw engine.
interface draw_if #(
  parameter int ADDR_W  = 22,
  parameter int COLOR_W = 16
);
  import draw_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CMD_OP_W-1:0]   cmd_op;
  logic [CMD_DATA_W-1:0] cmd_data;
  logic                  write_burst_req;
  logic                  write_burst_data_req;
  logic                  write_burst_data_finish;
  logic [ADDR_W-1:0]     addr;
  logic [9:0]            write_burst_len;
  logic [COLOR_W-1:0]    rgb;

  modport master (
    output cmd_valid, cmd_op, cmd_data, write_burst_data_req, write_burst_data_finish,
    input  cmd_ready, write_burst_req, addr, write_burst_len, rgb
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, write_burst_data_req, write_burst_data_finish,
    output cmd_ready, write_burst_req, addr, write_burst_len, rgb
  );
endinterface

// File: rtl/draw_cmd_fifo.sv
// Synchronous command FIFO with a registered read port (block-RAM style).
// DEPTH must be a power of two so the pointers wrap naturally.
module draw_cmd_fifo #(
  parameter int WIDTH = 264,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = rd_data_q;
  assign level   = level_q;

  // Storage is left unreset so it maps onto RAM; the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/draw_engine.sv
// Queued rectangle / clear-screen engine: pops commands, clips them to the
// screen and emits constant-colour write bursts of at most MAX_BURST pixels.
module draw_engine
  import draw_pkg::*;
#(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int COORD_W   = 10,
  parameter int COLOR_W   = 16,
  parameter int ADDR_W    = 22,
  parameter int MAX_BURST = 256,
  parameter int CMD_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  draw_if.slave                      bus,
  output logic                       cmd_done,
  output logic                       illegal_cmd,
  output logic                       busy,
  output logic [$clog2(CMD_DEPTH):0] fifo_level
);
  localparam int CW1    = COORD_W + 1;
  localparam int FIFO_W = CMD_OP_W + CMD_DATA_W;
  localparam int X_LSB  = field_lsb(FLD_X, COORD_W);
  localparam int Y_LSB  = field_lsb(FLD_Y, COORD_W);
  localparam int W_LSB  = field_lsb(FLD_W, COORD_W);
  localparam int H_LSB  = field_lsb(FLD_H, COORD_W);
  localparam int C_LSB  = field_lsb(FLD_COLOR, COORD_W);
  localparam logic [CW1-1:0] SCR_W = CW1'(SCREEN_W);
  localparam logic [CW1-1:0] SCR_H = CW1'(SCREEN_H);

  state_e             state_q, state_d;
  logic [CW1-1:0]     x_start_q, x_start_d, x_end_q, x_end_d, x_cur_q, x_cur_d;
  logic [CW1-1:0]     y_cur_q, y_cur_d, y_end_q, y_end_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [9:0]         len_q, len_d;
  logic               done_q, done_d, ill_q, ill_d;

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_W-1:0] fifo_rd;

  draw_cmd_fifo #(.WIDTH(FIFO_W), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.cmd_valid),
    .pop     (fifo_pop),
    .wr_data ({bus.cmd_op, bus.cmd_data}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  logic [CMD_OP_W-1:0] ld_op;
  logic [CW1-1:0]      ld_x, ld_y, ld_w, ld_h, w_eff, h_eff;
  logic                ld_clear, ld_draw, ld_empty;
  logic                unused_bits;

  assign ld_op       = fifo_rd[FIFO_W-1 -: CMD_OP_W];
  assign unused_bits = ^fifo_rd[CMD_DATA_W-1:C_LSB+COLOR_W];

  // Clip at COORD_W+1 bits; an origin off-screen yields an empty extent.
  always_comb begin
    ld_clear = (ld_op == OP_CLEAR);
    ld_draw  = (ld_op == OP_RECT) || ld_clear;
    ld_x = ld_clear ? '0    : CW1'(fifo_rd[X_LSB +: COORD_W]);
    ld_y = ld_clear ? '0    : CW1'(fifo_rd[Y_LSB +: COORD_W]);
    ld_w = ld_clear ? SCR_W : CW1'(fifo_rd[W_LSB +: COORD_W]);
    ld_h = ld_clear ? SCR_H : CW1'(fifo_rd[H_LSB +: COORD_W]);
    w_eff = '0;
    h_eff = '0;
    if (ld_x < SCR_W) w_eff = (ld_w < SCR_W - ld_x) ? ld_w : SCR_W - ld_x;
    if (ld_y < SCR_H) h_eff = (ld_h < SCR_H - ld_y) ? ld_h : SCR_H - ld_y;
    ld_empty = (w_eff == '0) || (h_eff == '0);
  end

  logic [CW1-1:0] x_adv, y_adv, seg_x, seg_y, seg_end, remain;
  logic           row_end, last_seg;
  logic [31:0]    seg_addr;
  logic [9:0]     seg_len;

  assign x_adv    = x_cur_q + CW1'(len_q);
  assign y_adv    = y_cur_q + 1'b1;
  assign row_end  = (x_adv >= x_end_q);
  assign last_seg = row_end && (y_adv >= y_end_q);

  // Position of the burst about to be issued: command origin in LOAD,
  // otherwise the successor of the burst just finished.
  always_comb begin
    seg_x   = x_cur_q;
    seg_y   = y_cur_q;
    seg_end = x_end_q;
    if (state_q == ST_LOAD) begin
      seg_x   = ld_x;
      seg_y   = ld_y;
      seg_end = ld_x + w_eff;
    end else if (row_end) begin
      seg_x = x_start_q;
      seg_y = y_adv;
    end else begin
      seg_x = x_adv;
    end
  end

  always_comb begin
    remain   = seg_end - seg_x;
    seg_len  = (32'(remain) > 32'(MAX_BURST)) ? 10'(MAX_BURST) : 10'(remain);
    seg_addr = 32'(seg_y) * 32'(SCREEN_W) + 32'(seg_x);
  end

  always_comb begin
    state_d   = state_q;
    x_start_d = x_start_q;
    x_end_d   = x_end_q;
    x_cur_d   = x_cur_q;
    y_cur_d   = y_cur_q;
    y_end_d   = y_end_q;
    color_d   = color_q;
    addr_d    = addr_q;
    len_d     = len_q;
    done_d    = 1'b0;
    ill_d     = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ld_draw && !ld_empty) begin
          x_start_d = ld_x;
          x_cur_d   = ld_x;
          x_end_d   = ld_x + w_eff;
          y_cur_d   = ld_y;
          y_end_d   = ld_y + h_eff;
          color_d   = fifo_rd[C_LSB +: COLOR_W];
          addr_d    = ADDR_W'(seg_addr);
          len_d     = seg_len;
          state_d   = ST_REQ;
        end else begin
          done_d  = ld_draw || (ld_op == OP_NOP);
          ill_d   = !(ld_draw || (ld_op == OP_NOP));
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.write_burst_data_req) begin
          state_d = bus.write_burst_data_finish ? ST_NEXT : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.write_burst_data_finish) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (last_seg) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          x_cur_d = seg_x;
          y_cur_d = seg_y;
          addr_d  = ADDR_W'(seg_addr);
          len_d   = seg_len;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      x_start_q <= '0;
      x_end_q   <= '0;
      x_cur_q   <= '0;
      y_cur_q   <= '0;
      y_end_q   <= '0;
      color_q   <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_start_q <= x_start_d;
      x_end_q   <= x_end_d;
      x_cur_q   <= x_cur_d;
      y_cur_q   <= y_cur_d;
      y_end_q   <= y_end_d;
      color_q   <= color_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      done_q    <= done_d;
      ill_q     <= ill_d;
    end
  end

  assign bus.cmd_ready       = ~fifo_full;
  assign bus.write_burst_req = (state_q == ST_REQ);
  assign bus.addr            = addr_q;
  assign bus.write_burst_len = len_q;
  assign bus.rgb             = color_q;
  assign cmd_done            = done_q;
  assign illegal_cmd         = ill_q;
  assign busy                = (state_q != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_draw_engine.sv
// Directed bench for draw_engine: vector table of single commands plus
// hand-written sequences for ordering, back-pressure and mid-burst reset.
module tb_draw_engine;
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_done, illegal_cmd, busy;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  draw_if #(.ADDR_W(22), .COLOR_W(16)) bus ();

  draw_engine dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .cmd_done    (cmd_done),
    .illegal_cmd (illegal_cmd),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  typedef struct {
    logic [21:0] addr;
    logic [9:0]  len;
    logic [15:0] rgb;
  } burst_t;

  typedef struct {
    logic [7:0]  op;
    int          x, y, w, h;
    logic [15:0] color;
    bit          fast;
    int          nb;
    int          a0, a1, a2;
    int          l0, l1, l2;
    int          done_n, ill_n;
  } vec_t;

  int     checks = 0;
  int     failures = 0;
  burst_t bq[$];
  int     ev_q[$];
  burst_t cur;
  bit     ctl_stall = 1'b0;
  bit     ctl_fast = 1'b0;
  bit     ctl_phase = 1'b0;
  int     max_level = 0;
  vec_t   vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [255:0] pack(input int x, input int y, input int w, input int h,
                                        input logic [15:0] c);
    logic [255:0] d;
    d = '1;
    d[9:0]   = x[9:0];
    d[19:10] = y[9:0];
    d[29:20] = w[9:0];
    d[39:30] = h[9:0];
    d[55:40] = c;
    return d;
  endfunction

  // One clock: sample outputs 1ns after the edge, then play controller.
  task automatic step();
    @(posedge clk);
    #1;
    if (cmd_done) ev_q.push_back(1);
    if (illegal_cmd) ev_q.push_back(2);
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    bus.write_burst_data_req    = 1'b0;
    bus.write_burst_data_finish = 1'b0;
    if (ctl_phase) chk("burst_hold", {bus.addr, bus.write_burst_len}, {cur.addr, cur.len});
    if (!ctl_stall) begin
      if (ctl_phase) begin
        bus.write_burst_data_finish = 1'b1;
        ctl_phase = 1'b0;
      end else if (bus.write_burst_req) begin
        cur.addr = bus.addr;
        cur.len  = bus.write_burst_len;
        cur.rgb  = bus.rgb;
        bq.push_back(cur);
        $display("burst addr=%0d len=%0d rgb=0x%04h", cur.addr, cur.len, cur.rgb);
        bus.write_burst_data_req = 1'b1;
        if (ctl_fast) bus.write_burst_data_finish = 1'b1;
        else ctl_phase = 1'b1;
      end
    end
  endtask

  task automatic push(input logic [7:0] op, input logic [255:0] d);
    int n;
    bit acc;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    do begin
      acc = bus.cmd_ready;
      step();
      n++;
    end while (!acc && n < 200);
    bus.cmd_valid = 1'b0;
    $display("push op=0x%02h accepted=%0d", op, acc);
    chk("push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic run_idle();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (busy && n < 20000);
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  function automatic int count_ev(input int code);
    int c;
    c = 0;
    foreach (ev_q[k]) if (ev_q[k] == code) c++;
    return c;
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea[3];
    int el[3];
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_data = '0;
    bus.write_burst_data_req = 1'b0;
    bus.write_burst_data_finish = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.write_burst_req), 0);
    chk("rst_addr", 32'(bus.addr), 0);
    chk("rst_len", 32'(bus.write_burst_len), 0);
    chk("rst_rgb", 32'(bus.rgb), 0);
    chk("rst_done", 32'(cmd_done), 0);
    chk("rst_ill", 32'(illegal_cmd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ready", 32'(bus.cmd_ready), 1);
    rst = 1'b0;

    //          op     x    y    w     h    color    fast nb  a0      a1      a2    l0   l1   l2  dn il
    vt[0] = '{8'h01, 10,   2,   4,    3, 16'hF800, 1'b0, 3, 1290,   1930,   2570, 4,   4,   4,   1, 0};
    vt[1] = '{8'h01, 0,    0,   600,  1, 16'h001F, 1'b1, 3, 0,      256,    512,  256, 256, 88,  1, 0};
    vt[2] = '{8'h01, 630,  478, 20,   5, 16'h07E0, 1'b0, 2, 306550, 307190, 0,    10,  10,  0,   1, 0};
    vt[3] = '{8'h01, 0,    10,  1023, 1, 16'hABCD, 1'b0, 3, 6400,   6656,   6912, 256, 256, 128, 1, 0};
    vt[4] = '{8'h01, 5,    479, 1,  100, 16'h1234, 1'b1, 1, 306565, 0,      0,    1,   0,   0,   1, 0};
    vt[5] = '{8'h01, 640,  0,   5,    1, 16'hFFFF, 1'b0, 0, 0,      0,      0,    0,   0,   0,   1, 0};
    vt[6] = '{8'h01, 0,    480, 5,    1, 16'hFFFF, 1'b0, 0, 0,      0,      0,    0,   0,   0,   1, 0};
    vt[7] = '{8'h01, 3,    3,   0,    2, 16'h5555, 1'b0, 0, 0,      0,      0,    0,   0,   0,   1, 0};
    vt[8] = '{8'h7F, 3,    3,   4,    2, 16'h5555, 1'b0, 0, 0,      0,      0,    0,   0,   0,   0, 1};
    vt[9] = '{8'h00, 3,    3,   4,    2, 16'h5555, 1'b0, 0, 0,      0,      0,    0,   0,   0,   1, 0};

    for (int i = 0; i < 10; i++) begin
      bq.delete();
      ev_q.delete();
      ctl_fast = vt[i].fast;
      push(vt[i].op, pack(vt[i].x, vt[i].y, vt[i].w, vt[i].h, vt[i].color));
      run_idle();
      ea = '{vt[i].a0, vt[i].a1, vt[i].a2};
      el = '{vt[i].l0, vt[i].l1, vt[i].l2};
      chk($sformatf("v%0d_nbursts", i), bq.size(), vt[i].nb);
      for (int b = 0; b < 3; b++) begin
        if (b < vt[i].nb && b < bq.size()) begin
          chk($sformatf("v%0d_b%0d_addr", i, b), 32'(bq[b].addr), ea[b]);
          chk($sformatf("v%0d_b%0d_len", i, b), 32'(bq[b].len), el[b]);
          chk($sformatf("v%0d_b%0d_rgb", i, b), 32'(bq[b].rgb), 32'(vt[i].color));
        end
      end
      chk($sformatf("v%0d_done", i), count_ev(1), vt[i].done_n);
      chk($sformatf("v%0d_ill", i), count_ev(2), vt[i].ill_n);
    end
    ctl_fast = 1'b0;

    // Trivial commands retire in queue order.
    bq.delete();
    ev_q.delete();
    push(8'h01, pack(1, 1, 0, 4, 16'h0));
    push(8'h7F, pack(1, 1, 4, 4, 16'h0));
    push(8'h00, pack(0, 0, 0, 0, 16'h0));
    run_idle();
    chk("mix_bursts", bq.size(), 0);
    chk("mix_events", ev_q.size(), 3);
    if (ev_q.size() == 3) begin
      chk("mix_ev0", ev_q[0], 1);
      chk("mix_ev1", ev_q[1], 2);
      chk("mix_ev2", ev_q[2], 1);
    end

    // Back-pressure: controller stalled, five pushes fill one pop + four slots.
    bq.delete();
    ev_q.delete();
    max_level = 0;
    ctl_stall = 1'b1;
    for (int k = 0; k < 5; k++) push(8'h01, pack(1, k, 3, 1, 16'(16'h0100 + k)));
    chk("full_ready", 32'(bus.cmd_ready), 0);
    chk("full_level", 32'(fifo_level), 4);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 8'h01;
    bus.cmd_data  = pack(9, 9, 9, 1, 16'hDEAD);
    repeat (3) step();
    bus.cmd_valid = 1'b0;
    chk("full_push_ignored", 32'(fifo_level), 4);
    chk("stall_no_burst", bq.size(), 0);
    ctl_stall = 1'b0;
    run_idle();
    chk("max_level", max_level, 4);
    chk("bp_bursts", bq.size(), 5);
    chk("bp_done", count_ev(1), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < bq.size()) begin
        chk($sformatf("bp%0d_addr", k), 32'(bq[k].addr), k * 640 + 1);
        chk($sformatf("bp%0d_len", k), 32'(bq[k].len), 3);
        chk($sformatf("bp%0d_rgb", k), 32'(bq[k].rgb), 32'h0100 + k);
      end
    end

    // Reset in the DATA phase of a CLEAR with another command queued.
    bq.delete();
    ev_q.delete();
    push(8'h02, pack(5, 5, 1, 1, 16'h1234));
    push(8'h01, pack(7, 7, 2, 2, 16'h4321));
    begin
      int n;
      n = 0;
      while (bq.size() < 2 && n < 100) begin
        step();
        n++;
      end
    end
    chk("clr_bursts_seen", bq.size(), 2);
    if (bq.size() >= 2) begin
      chk("clr_b0_addr", 32'(bq[0].addr), 0);
      chk("clr_b0_len", 32'(bq[0].len), 256);
      chk("clr_b0_rgb", 32'(bq[0].rgb), 32'h1234);
      chk("clr_b1_addr", 32'(bq[1].addr), 256);
    end
    step();
    rst = 1'b1;
    bus.write_burst_data_req = 1'b0;
    bus.write_burst_data_finish = 1'b0;
    ctl_phase = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_req", 32'(bus.write_burst_req), 0);
    chk("mrst_addr", 32'(bus.addr), 0);
    chk("mrst_len", 32'(bus.write_burst_len), 0);
    chk("mrst_rgb", 32'(bus.rgb), 0);
    chk("mrst_done", 32'(cmd_done), 0);
    chk("mrst_ill", 32'(illegal_cmd), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_level", 32'(fifo_level), 0);
    chk("mrst_ready", 32'(bus.cmd_ready), 1);
    rst = 1'b0;
    bq.delete();
    ev_q.delete();
    repeat (5) step();
    chk("flush_no_bursts", bq.size(), 0);
    chk("flush_no_events", ev_q.size(), 0);

    // Fresh command after reset, including push-to-request latency.
    push(8'h01, pack(3, 4, 5, 1, 16'h0F0F));
    chk("lat_e0_req", 32'(bus.write_burst_req), 0);
    step();
    chk("lat_e1_req", 32'(bus.write_burst_req), 0);
    step();
    chk("lat_e2_req", 32'(bus.write_burst_req), 1);
    run_idle();
    chk("post_bursts", bq.size(), 1);
    if (bq.size() >= 1) begin
      chk("post_addr", 32'(bq[0].addr), 2563);
      chk("post_len", 32'(bq[0].len), 5);
      chk("post_rgb", 32'(bq[0].rgb), 32'h0F0F);
    end
    chk("post_done", count_ev(1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
